// File: rtl/adc_hue_mapper.sv
// ============================================================================
//  Module   : adc_hue_mapper
//  Purpose  : Averages ADC samples of one channel, maps the average onto a
//             six-sector hue wheel and loads red/green/blue PWM compares on
//             the downstream PWM period boundary (frame_sync).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module adc_hue_mapper #(
    parameter int         ADC_W    = 10,
    parameter int         CTR_LEN  = 8,
    parameter int         AVG_LOG2 = 2,
    parameter logic [3:0] CHANNEL  = 4'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADC_W-1:0]   sample,
    input  logic [3:0]         sample_channel,
    input  logic               new_sample,
    output logic               sample_ready,
    input  logic               frame_sync,
    output logic [CTR_LEN-1:0] red,
    output logic [CTR_LEN-1:0] green,
    output logic [CTR_LEN-1:0] blue,
    output logic               update
);

    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int H_W   = ADC_W + 3;

    // Sector boundaries on the hue axis h = 0 .. 6*2^CTR_LEN-1
    localparam logic [H_W-1:0]     C_SEC1 = H_W'(1 << CTR_LEN);
    localparam logic [H_W-1:0]     C_SEC2 = H_W'(2 << CTR_LEN);
    localparam logic [H_W-1:0]     C_SEC3 = H_W'(3 << CTR_LEN);
    localparam logic [H_W-1:0]     C_SEC4 = H_W'(4 << CTR_LEN);
    localparam logic [H_W-1:0]     C_SEC5 = H_W'(5 << CTR_LEN);
    localparam logic [CTR_LEN-1:0] C_M    = '1;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_MAP   = 2'd1,
        ST_PEND  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [AVG_LOG2-1:0] cnt_q, cnt_d;
    logic [CTR_LEN-1:0]  hold_r_q, hold_r_d, hold_g_q, hold_g_d, hold_b_q, hold_b_d;
    logic [CTR_LEN-1:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic                update_q, update_d;
    logic                ready_q, ready_d;

    logic                w_xfer;
    logic [ADC_W-1:0]    w_avg;
    logic [H_W-1:0]      w_prod;
    logic [H_W-1:0]      w_h;
    logic [CTR_LEN-1:0]  w_f;
    logic [CTR_LEN-1:0]  w_r, w_g, w_b;

    // A sample counts only when offered, accepted and on our channel
    assign w_xfer = new_sample & ready_q & (sample_channel == CHANNEL) & (state_q == ST_ACCUM);

    // avg*6 built from shifts; h rescales the product to the compare width
    assign w_avg  = acc_q[ACC_W-1:AVG_LOG2];
    assign w_prod = ({3'b000, w_avg} << 2) + ({3'b000, w_avg} << 1);
    assign w_h    = w_prod >> (ADC_W - CTR_LEN);
    assign w_f    = w_h[CTR_LEN-1:0];

    // Hue wheel: pick the sector by range and ramp one channel by f
    always_comb begin
        w_r = C_M;
        w_g = w_f;
        w_b = '0;
        if (w_h < C_SEC1) begin
            w_r = C_M;       w_g = w_f;       w_b = '0;
        end else if (w_h < C_SEC2) begin
            w_r = C_M - w_f; w_g = C_M;       w_b = '0;
        end else if (w_h < C_SEC3) begin
            w_r = '0;        w_g = C_M;       w_b = w_f;
        end else if (w_h < C_SEC4) begin
            w_r = '0;        w_g = C_M - w_f; w_b = C_M;
        end else if (w_h < C_SEC5) begin
            w_r = w_f;       w_g = '0;        w_b = C_M;
        end else begin
            w_r = C_M;       w_g = '0;        w_b = C_M - w_f;
        end
    end

    // Next-state logic: accumulate, map once, then wait for the period boundary
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hold_r_d = hold_r_q;
        hold_g_d = hold_g_q;
        hold_b_d = hold_b_q;
        red_d    = red_q;
        green_d  = green_q;
        blue_d   = blue_q;
        update_d = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                if (w_xfer) begin
                    acc_d = acc_q + {{AVG_LOG2{1'b0}}, sample};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = ST_MAP;
                    end
                end
            end
            ST_MAP: begin
                hold_r_d = w_r;
                hold_g_d = w_g;
                hold_b_d = w_b;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = ST_PEND;
            end
            ST_PEND: begin
                if (frame_sync) begin
                    red_d    = hold_r_q;
                    green_d  = hold_g_q;
                    blue_d   = hold_b_q;
                    update_d = 1'b1;
                    state_d  = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
        ready_d = (state_d == ST_ACCUM);
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_ACCUM;
            acc_q    <= '0;
            cnt_q    <= '0;
            hold_r_q <= '0;
            hold_g_q <= '0;
            hold_b_q <= '0;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
            update_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hold_r_q <= hold_r_d;
            hold_g_q <= hold_g_d;
            hold_b_q <= hold_b_d;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
            update_q <= update_d;
            ready_q  <= ready_d;
        end
    end

    assign red          = red_q;
    assign green        = green_q;
    assign blue         = blue_q;
    assign update       = update_q;
    assign sample_ready = ready_q;

endmodule

`default_nettype wire
